// File: rtl/sync_counter_pkg.sv
// Shared types and constants for the 3-bit counter tracker.
package sync_counter_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    typedef enum logic [1:0] {
        DC_HOLD,
        DC_UP,
        DC_DOWN,
        DC_ILLEGAL
    } delta_cls_e;

    localparam logic [2:0] DELTA_UP = 3'd1;
    localparam logic [2:0] DELTA_DN = 3'd7;

endpackage

// File: rtl/sync_delta_classify.sv
// Classifies the modulo-8 difference between two successive counter samples.
module sync_delta_classify
    import sync_counter_pkg::*;
(
    input  logic [2:0]  prev,
    input  logic [2:0]  count_in,
    output delta_cls_e  cls
);

    logic [2:0] delta;

    // 3-bit subtraction gives the wrap-around distance for free (7->0 is +1).
    assign delta = count_in - prev;

    always_comb begin
        cls = DC_ILLEGAL;
        if (delta == 3'd0) begin
            cls = DC_HOLD;
        end else if (delta == DELTA_UP) begin
            cls = DC_UP;
        end else if (delta == DELTA_DN) begin
            cls = DC_DOWN;
        end
    end

endmodule

// File: rtl/sync_counter_tracker.sv
// Tracks a 3-bit up/down counter: direction, steps, illegal jumps, wide position.
// Define SYNC_TRACKER_POS_SAT_EN to saturate pos instead of wrapping.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ACQUIRE | no reference yet; next sample becomes prev
// ST_VERIFY  | one reference held; a legal delta confirms lock
// ST_LOCKED  | tracking; steps move pos, illegal samples count toward relock
module sync_counter_tracker
    import sync_counter_pkg::*;
#(
    parameter int POS_W     = 16,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [2:0]       count_in,
    input  logic             clr,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [3:0]       BAD_LIM = 4'(ERR_LIMIT);

    state_e           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [3:0]       bad_run_q, bad_run_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    delta_cls_e       cls;
    logic [POS_W-1:0] pos_up, pos_dn;

    sync_delta_classify u_classify (
        .prev     (prev_q),
        .count_in (count_in),
        .cls      (cls)
    );

`ifdef SYNC_TRACKER_POS_SAT_EN
    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    assign pos_up = (pos_q == POS_MAX) ? pos_q : pos_q + POS_ONE;
    assign pos_dn = (pos_q == POS_MIN) ? pos_q : pos_q - POS_ONE;
`else
    assign pos_up = pos_q + POS_ONE;
    assign pos_dn = pos_q - POS_ONE;
`endif

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        bad_run_d = bad_run_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (sample_en) begin
            prev_d = count_in;
            case (state_q)
                ST_ACQUIRE: state_d = ST_VERIFY;
                ST_VERIFY: begin
                    if (cls != DC_ILLEGAL) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    case (cls)
                        DC_UP: begin
                            pos_d     = pos_up;
                            dir_d     = 1'b1;
                            step_d    = 1'b1;
                            bad_run_d = 4'd0;
                        end
                        DC_DOWN: begin
                            pos_d     = pos_dn;
                            dir_d     = 1'b0;
                            step_d    = 1'b1;
                            bad_run_d = 4'd0;
                        end
                        DC_HOLD: bad_run_d = 4'd0;
                        default: begin
                            err_d = 1'b1;
                            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                            if (bad_run_q + 4'd1 == BAD_LIM) begin
                                state_d   = ST_ACQUIRE;
                                bad_run_d = 4'd0;
                            end else begin
                                bad_run_d = bad_run_q + 4'd1;
                            end
                        end
                    endcase
                end
                default: state_d = ST_ACQUIRE;
            endcase
        end

        // Clear only touches the accumulators; step still reports the sample.
        if (clr) begin
            pos_d     = '0;
            err_cnt_d = 8'd0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_ACQUIRE;
            prev_q    <= 3'd0;
            bad_run_q <= 4'd0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            bad_run_q <= bad_run_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pos     = pos_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign err     = err_q;
    assign locked  = locked_q;
    assign err_cnt = err_cnt_q;

endmodule
